// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bus between a wide-operand producer and nibble_serial_adder_ctrl.
//   start        : request pulse (producer -> controller)
//   a, b, cin    : operands and carry-in, sampled when start is accepted
//   sub          : subtract select, present only with NIBBLE_SERIAL_SUB_EN
//   busy, done   : operation in progress / one-cycle completion pulse
//   sum, cout    : assembled result and final carry, held until the next start
// master = operand producer, slave = controller.
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef NIBBLE_SERIAL_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef NIBBLE_SERIAL_SUB_EN
    modport master (output start, a, b, cin, sub, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input  busy, done, sum, cout);
    modport slave  (input  start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Sequences a WIDTH-bit add through a shared external 4-bit ripple-carry adder,
// one nibble per clock, LSB nibble first.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   bus (slave)  : start/a/b/cin request, busy/done/sum/cout result
//   add_a/add_b  : operand nibbles to the 4-bit adder (0 outside RUN)
//   add_cin      : carry into the 4-bit adder (0 outside RUN)
//   add_sum/add_cout : combinational return from the 4-bit adder
// Optional feature macro: NIBBLE_SERIAL_SUB_EN adds bus.sub (A-B via ~B and carry-in 1).
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    nibble_serial_adder_ctrl_if.slave   bus,
    output logic [3:0]                  add_a,
    output logic [3:0]                  add_b,
    output logic                        add_cin,
    input  logic [3:0]                  add_sum,
    input  logic                        add_cout
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e            state_q,   state_d;
    logic [IDXW-1:0]   idx_q,     idx_d;
    logic              carry_q,   carry_d;
    logic [WIDTH-1:0]  a_q,       a_d;
    logic [WIDTH-1:0]  b_q,       b_d;
    logic [WIDTH-1:0]  sum_q,     sum_d;
    logic              cout_q,    cout_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic [3:0]        add_a_q,   add_a_d;
    logic [3:0]        add_b_q,   add_b_d;
    logic              add_cin_q, add_cin_d;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        add_a_d   = 4'h0;
        add_b_d   = 4'h0;
        add_cin_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    idx_d   = '0;
`ifdef NIBBLE_SERIAL_SUB_EN
                    // Subtract as A + ~B + 1; cin is ignored in that mode.
                    b_d     = bus.sub ? ~bus.b : bus.b;
                    carry_d = bus.sub | bus.cin;
`else
                    b_d     = bus.b;
                    carry_d = bus.cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = add_sum;
                carry_d = add_cout;
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered, so decode them from the next-cycle values.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        if (state_d == RUN) begin
            add_a_d   = a_d[{idx_d, 2'b00} +: 4];
            add_b_d   = b_d[{idx_d, 2'b00} +: 4];
            add_cin_d = carry_d;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            add_a_q   <= 4'h0;
            add_b_q   <= 4'h0;
            add_cin_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_cin  = add_cin_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16) with a behavioural
// 4-bit adder and a wide-arithmetic reference model.
module tb_nibble_serial_adder_ctrl;
    localparam int unsigned W   = 16;
    localparam int unsigned NIB = W / 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] add_a, add_b, add_sum;
    logic       add_cin, add_cout;

    int n_checks;
    int n_pass;

    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // Stand-in for the shared 4-bit ripple-carry adder.
    always_comb {add_cout, add_sum} = 5'(add_a) + 5'(add_b) + 5'(add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Wide reference: plain arithmetic on the full operands.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
        if (sub) return (W+1)'(a) + (W+1)'(~b) + (W+1)'(1);
        return (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
    endfunction

    // From a negedge in RUN, count busy cycles until done (bounded).
    task automatic wait_done(input int already_busy, output int busy_cycles, output logic got_done);
        busy_cycles = already_busy;
        got_done    = 1'b0;
        for (int i = 0; i < 40 && !got_done; i++) begin
            if (bus.done) got_done = 1'b1;
            else begin
                if (bus.busy) busy_cycles++;
                @(negedge clk);
            end
        end
    endtask

    // Issue one operation from IDLE at a negedge and check it to completion.
    task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_cin, input logic op_sub);
        logic [W:0]  exp;
        logic [3:0]  exp_b0;
        int          bc;
        logic        gd;
        exp    = model(op_a, op_b, op_cin, op_sub);
        exp_b0 = op_sub ? ~op_b[3:0] : op_b[3:0];
        bus.a     = op_a;
        bus.b     = op_b;
        bus.cin   = op_cin;
`ifdef NIBBLE_SERIAL_SUB_EN
        bus.sub   = op_sub;
`endif
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, "_add_a0"},   32'(add_a),   32'(op_a[3:0]));
        check({tag, "_add_b0"},   32'(add_b),   32'(exp_b0));
        check({tag, "_add_cin0"}, 32'(add_cin), 32'(op_sub | op_cin));
        wait_done(0, bc, gd);
        check({tag, "_done_seen"},  32'(gd),        32'(1));
        check({tag, "_busy_cycles"}, 32'(bc),       32'(NIB));
        check({tag, "_sum"},        32'(bus.sum),   32'(exp[W-1:0]));
        check({tag, "_cout"},       32'(bus.cout),  32'(exp[W]));
        check({tag, "_idle_add_a"}, 32'(add_a),     32'(0));
    endtask

    initial begin
        int         bc;
        logic       gd;
        logic       seen_activity;
        logic [W-1:0] ra, rb;
        logic       rc, rs;

        n_checks = 0;
        n_pass   = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
        bus.sub   = 1'b0;
`endif
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_sum",  32'(bus.sum),  32'(0));
        check("rst_cout", 32'(bus.cout), 32'(0));
        check("rst_add_a", 32'(add_a),   32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven addition vectors with hand-computed expectations.
        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0);
            check($sformatf("vec%0d_tbl_sum", i),  32'(bus.sum),  32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_tbl_cout", i), 32'(bus.cout), 32'(vecs[i].exp_cout));
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'(0));
        end

        // Second start during RUN is ignored; operand change after acceptance has no effect.
        bus.a = 16'h0F0F; bus.b = 16'h00F1; bus.cin = 1'b0; bus.start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
        bus.sub = 1'b0;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 16'hAAAA; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(2, bc, gd);
        check("ign_done_seen", 32'(gd), 32'(1));
        check("ign_busy_cycles", 32'(bc), 32'(NIB));
        check("ign_sum",  32'(bus.sum),  32'(16'h1000));
        check("ign_cout", 32'(bus.cout), 32'(0));

        // Start held through DONE: ignored there, accepted on the following IDLE cycle.
        bus.a = 16'h0001; bus.b = 16'h0002; bus.cin = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        check("held_idle_busy", 32'(bus.busy), 32'(0));
        check("held_idle_done", 32'(bus.done), 32'(0));
        @(negedge clk);
        bus.start = 1'b0;
        check("held_accept_busy", 32'(bus.busy), 32'(1));
        wait_done(0, bc, gd);
        check("held_done_seen", 32'(gd), 32'(1));
        check("held_busy_cycles", 32'(bc), 32'(NIB));
        check("held_sum",  32'(bus.sum),  32'(16'h0003));
        check("held_cout", 32'(bus.cout), 32'(0));
        @(negedge clk);

`ifdef NIBBLE_SERIAL_SUB_EN
        run_op("sub0", 16'h0005, 16'h0007, 1'b0, 1'b1);
        check("sub0_tbl_sum",  32'(bus.sum),  32'(16'hFFFE));
        check("sub0_tbl_cout", 32'(bus.cout), 32'(0));
        @(negedge clk);
        run_op("sub1", 16'h0007, 16'h0005, 1'b0, 1'b1);
        check("sub1_tbl_sum",  32'(bus.sum),  32'(16'h0002));
        check("sub1_tbl_cout", 32'(bus.cout), 32'(1));
        @(negedge clk);
`endif

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
`ifdef NIBBLE_SERIAL_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rs);
            repeat (1 + ($urandom % 3)) @(negedge clk);
        end

        // Reset mid-operation: all outputs clear asynchronously, no done afterwards.
        bus.a = 16'h8000; bus.b = 16'h8000; bus.cin = 1'b0; bus.start = 1'b1;
`ifdef NIBBLE_SERIAL_SUB_EN
        bus.sub = 1'b0;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_sum",  32'(bus.sum),  32'(0));
        check("abort_cout", 32'(bus.cout), 32'(0));
        check("abort_add_a", 32'(add_a),   32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen_activity = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen_activity = 1'b1;
        end
        check("abort_no_spurious", 32'(seen_activity), 32'(0));

        // Block still works after the abort.
        run_op("post_abort", 16'h1111, 16'h2222, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that computes a WIDTH-bit add using the team's existing 4-bit ripple-carry adder, one nibble per clock, LSB nibble first.
- Owns the adder's operand, carry-in and result ports.
- Latches wide operands on a start pulse, steps through nibbles while registering the inter-nibble carry, and presents the assembled sum with a done pulse.
- Sits between wide-operand producers and the single shared 4-bit adder, so wide arithmetic needs no extra adder hardware.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived number of nibble steps (localparam, not overridable).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  WIDTH  operand A; sampled when start is accepted.
- b  in  WIDTH  operand B; sampled when start is accepted.
- cin  in  1  carry-in to nibble 0; sampled when start is accepted.
- busy  out  1  high while an operation is in progress (RUN).
- done  out  1  one-cycle pulse; sum/cout are valid.
- sum  out  WIDTH  result register; holds until the next accepted start.
- cout  out  1  carry out of the MSB nibble; holds with sum.
- add_a  out  4  operand nibble driven to the 4-bit adder.
- add_b  out  4  operand nibble driven to the 4-bit adder.
- add_cin  out  1  carry-in driven to the 4-bit adder.
- add_sum  in  4  4-bit adder sum (combinational return).
- add_cout  in  1  4-bit adder carry-out (combinational return).

Behaviour:
- Clock/reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, idx=0, carry register=0, a/b registers=0, busy=0, done=0, sum=0, cout=0.
- States:
  - IDLE: start=1 at edge E0 latches a, b, cin into registers, clears idx to 0, and moves to RUN. start=0 stays in IDLE.
  - RUN: busy=1. add_a = a_reg[4*idx+3:4*idx], add_b = b_reg nibble idx, add_cin = carry register (cin_reg when idx=0). Each edge writes add_sum into sum[4*idx+3:4*idx] and add_cout into the carry register, then increments idx. After the edge that writes idx=NIB-1: cout <= add_cout, move to DONE.
  - DONE: done=1, busy=0 for exactly one cycle, then unconditional return to IDLE.
- Latency: start accepted at E0; done is high during the cycle after edge E(NIB). With WIDTH=16 the final capture is at E4 and done is high during cycle 5.
- In IDLE and DONE, add_a/add_b/add_cin are driven to 0.
- start while in RUN or DONE is ignored; no queuing. Changes to a/b/cin after acceptance do not affect the result.
- sum is updated nibble by nibble during RUN. It is only guaranteed valid when done=1 and afterwards, until the next accepted start.
- Wrap-around: all-ones + 1 ripples the carry through every nibble. Result is sum=0, cout=1; no saturation.
- Reset mid-operation (rst_n low in any state) immediately forces all reset values. The partial result is discarded and done is never asserted for the aborted operation.
- Simultaneous start and reset release: start is not sampled until the first edge with rst_n high.
- idx width is clog2(NIB), minimum 1 bit. For WIDTH=4, RUN lasts exactly one cycle.

Optional Feature:
- Macro: NIBBLE_SERIAL_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a/b at start.
  - sub=1 latches b as ~b and forces the carry into nibble 0 to 1 (cin ignored), giving A-B. cout=1 means no borrow.
  - sub=0 behaves exactly as the base block.
- Undefined: the sub port is absent and only addition is supported.

Test Plan:
- WIDTH=16: a=0x1234, b=0x4321, cin=0, start pulse -> busy high 4 cycles, done high in cycle 5, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. Also a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1.
- Start accepted with a=0x0F0F, b=0x00F1, cin=0; at cycle 2 change a=0xAAAA and pulse start again -> second start ignored, sum=0x1000, cout=0. A start held high during the DONE cycle is also ignored; it is accepted on the following IDLE cycle.
- Start a=0x8000, b=0x8000; drop rst_n low in cycle 3 -> busy, done, sum, cout go to 0 asynchronously. After release, idle until a new start; no spurious done.
- NIBBLE_SERIAL_SUB_EN defined: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0. Then a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
